// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package rv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - memory, datapath and redirect signals of the fetch unit
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_ready;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc, instr_pc_plus4,
    input  instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc, instr_pc_plus4,
    output instr_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered storage, flush and occupancy count
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr];

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - in-order instruction fetch with prefetch buffer and PC redirect
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = $clog2(DEPTH + 1);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   discard;
  logic [FW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            pcq_full;
  logic            pcq_empty;
  logic [XLEN-1:0] pcq_head;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            req;
  logic            accept;
  logic            redirect;
  logic            rvalid;
  logic            credit_ok;

  assign redirect  = bus.redirect_valid;
  assign rvalid    = bus.imem_rvalid;
  // In-flight requests reserve FIFO space so every response has a slot.
  assign credit_ok = (int'(fifo_count) + int'(outstanding)) < DEPTH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= BOOT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     req = credit_ok && !pcq_full && !redirect;
      default: state_d = BOOT;
    endcase
  end

  assign accept        = req && bus.imem_ready;
  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else begin
      if (redirect)    fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (accept) fetch_pc <= pc_plus4(fetch_pc);
      // Everything still in flight after this edge belongs to the old stream.
      if (redirect)                     discard <= outstanding - OW'(rvalid);
      else if (rvalid && discard != '0) discard <= discard - OW'(1);
    end
  end

  // The PC queue is never flushed: discarded responses still pop their PC.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rvalid),
    .pop_data  (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (outstanding)
  );

  assign push_entry = '{pc: pcq_head, instr: bus.imem_rdata};
  assign fifo_push  = rvalid && (discard == '0) && !redirect;
  assign fifo_pop   = !fifo_empty && bus.instr_ready && !redirect;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_prefetch (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.instr_valid    = !fifo_empty;
  assign bus.instr          = fifo_empty ? '0 : head.instr;
  assign bus.instr_pc       = fifo_empty ? '0 : head.pc;
  assign bus.instr_pc_plus4 = fifo_empty ? '0 : pc_plus4(head.pc);

  a_rvalid_has_request: assert property (@(posedge clk) disable iff (!rst)
    rvalid |-> !pcq_empty);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  logic mem_hold;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: in-order responses, one cycle after acceptance unless held.
  logic        acc;
  logic [31:0] acc_addr;
  logic [31:0] mq[$];
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      acc      = bus.imem_req && bus.imem_ready && rst;
      acc_addr = bus.imem_addr;
      #1;
      if (!rst)     mq.delete();
      else if (acc) mq.push_back(acc_addr);
      if (rst && !mem_hold && mq.size() > 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(mq.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic ereq, input logic [31:0] eaddr,
                             input logic evalid, input logic [31:0] epc);
    logic [31:0] pc4;
    pc4 = epc + 32'd4;
    #1;
    chk({tag, ".req"},   32'(bus.imem_req),    32'(ereq));
    chk({tag, ".addr"},  bus.imem_addr,        eaddr);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(evalid));
    chk({tag, ".pc"},    bus.instr_pc,         evalid ? epc : 32'h0);
    chk({tag, ".instr"}, bus.instr,            evalid ? mem_word(epc) : 32'h0);
    chk({tag, ".pc4"},   bus.instr_pc_plus4,   evalid ? pc4 : 32'h0);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic hold);
    @(negedge clk);
    rst                = 1'b0;
    mem_hold           = hold;
    bus.imem_ready     = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        iready;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs = '{
      '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0},   // BOOT cycle
      '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0},
      '{1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0},
      '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0},
      '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4},
      '{1'b1, 1'b0, 1'b1, 32'd16, 1'b1, 32'd8},   // datapath stalls
      '{1'b1, 1'b0, 1'b1, 32'd20, 1'b1, 32'd8},
      '{1'b1, 1'b0, 1'b0, 32'd24, 1'b1, 32'd8},
      '{1'b1, 1'b0, 1'b0, 32'd24, 1'b1, 32'd8},
      '{1'b1, 1'b0, 1'b0, 32'd24, 1'b1, 32'd8},
      '{1'b1, 1'b1, 1'b0, 32'd24, 1'b1, 32'd8},   // drain starts
      '{1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd12},
      '{1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16},
      '{1'b1, 1'b1, 1'b1, 32'd32, 1'b1, 32'd20},
      '{1'b0, 1'b1, 1'b1, 32'd36, 1'b1, 32'd24},  // memory stalls
      '{1'b0, 1'b1, 1'b1, 32'd36, 1'b1, 32'd28},
      '{1'b0, 1'b1, 1'b1, 32'd36, 1'b1, 32'd32},
      '{1'b1, 1'b1, 1'b1, 32'd36, 1'b0, 32'd0},
      '{1'b1, 1'b1, 1'b1, 32'd40, 1'b0, 32'd0},
      '{1'b1, 1'b1, 1'b1, 32'd44, 1'b1, 32'd36}
    };

    rst                = 1'b0;
    mem_hold           = 1'b0;
    bus.imem_ready     = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);
    check_cycle("reset", 1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      bus.imem_ready  = vecs[i].ready;
      bus.instr_ready = vecs[i].iready;
      check_cycle($sformatf("v%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid, vecs[i].epc);
    end

    // Two requests held in flight, then back-to-back redirects.
    do_reset(1'b1);
    check_cycle("b0", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle(); check_cycle("b1", 1'b1, 32'h0, 1'b0, 32'h0);
    next_cycle(); check_cycle("b2", 1'b1, 32'h4, 1'b0, 32'h0);
    next_cycle(); check_cycle("b3_limit", 1'b0, 32'h8, 1'b0, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    check_cycle("b3_redir", 1'b0, 32'h8, 1'b0, 32'h0);
    next_cycle();
    bus.redirect_pc = 32'h0000_0143;
    check_cycle("b4_redir2", 1'b0, 32'h100, 1'b0, 32'h0);
    next_cycle();
    bus.redirect_valid = 1'b0;
    mem_hold           = 1'b0;
    check_cycle("b5", 1'b0, 32'h140, 1'b0, 32'h0);
    next_cycle(); check_cycle("b6_drop", 1'b0, 32'h140, 1'b0, 32'h0);
    next_cycle(); check_cycle("b7_drop", 1'b1, 32'h140, 1'b0, 32'h0);
    next_cycle(); check_cycle("b8", 1'b1, 32'h144, 1'b0, 32'h0);
    next_cycle(); check_cycle("b9", 1'b1, 32'h148, 1'b1, 32'h140);

    // Redirect together with a response and a pop.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    check_cycle("b9_redir", 1'b0, 32'h148, 1'b1, 32'h140);
    next_cycle();
    bus.redirect_valid = 1'b0;
    check_cycle("b10_flushed", 1'b1, 32'h200, 1'b0, 32'h0);
    next_cycle(); check_cycle("b11", 1'b1, 32'h204, 1'b0, 32'h0);
    next_cycle(); check_cycle("b12", 1'b1, 32'h208, 1'b1, 32'h200);
    next_cycle(); check_cycle("b13", 1'b1, 32'h20C, 1'b1, 32'h204);

    // Address wrap at the top of the address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    check_cycle("b13_redir", 1'b0, 32'h20C, 1'b1, 32'h204);
    next_cycle();
    bus.redirect_valid = 1'b0;
    check_cycle("b14", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    next_cycle(); check_cycle("b15_wrap", 1'b1, 32'h0, 1'b0, 32'h0);
    next_cycle(); check_cycle("b16", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC);

    // Asynchronous reset mid-cycle, then restart at RESET_PC.
    #1 rst = 1'b0;
    check_cycle("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    rst = 1'b1;
    check_cycle("r0", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle(); check_cycle("r1", 1'b1, 32'h0, 1'b0, 32'h0);
    next_cycle(); check_cycle("r2", 1'b1, 32'h4, 1'b0, 32'h0);
    next_cycle(); check_cycle("r3", 1'b1, 32'h8, 1'b1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle datapath/controller.
- Issues in-order, word-aligned requests to an instruction memory with a req/ready and rvalid handshake, tracking up to 2 requests in flight.
- Buffers returned words with their PC in a small prefetch FIFO and presents them to the datapath with a valid/ready handshake.
- Accepts PC redirects (branch/jump/jalr target) from the datapath, flushes buffered and in-flight work, and restarts fetch at the target.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2).
- MAX_OUTSTANDING, 2, maximum memory requests in flight.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- imem_req  out  1  request valid.
- imem_addr  out  32  request word address, bits[1:0] always 0.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance.
- imem_rdata  in  32  response instruction word.
- instr_valid  out  1  FIFO head valid.
- instr  out  32  head instruction.
- instr_pc  out  32  head PC.
- instr_pc_plus4  out  32  head PC + 4, mod 2^32.
- instr_ready  in  1  datapath consumes head this cycle.
- redirect_valid  in  1  datapath requests a redirect.
- redirect_pc  in  32  redirect target; bits[1:0] ignored and forced to 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; FSM=BOOT.
  - Outputs: imem_req=0, instr_valid=0, instr/instr_pc/instr_pc_plus4=0.
- FSM:
  - BOOT: one cycle after reset release, imem_req=0, then RUN.
  - RUN: normal operation. No other states.
- Request issue (RUN): imem_req=1 when (fifo_count + outstanding) < DEPTH, outstanding < MAX_OUTSTANDING, and redirect_valid=0.
  - imem_addr=fetch_pc.
  - On imem_req & imem_ready: fetch_pc += 4 (wraps at 2^32), outstanding++.
  - imem_req and imem_addr are combinational from registered state; imem_addr is stable while imem_req=1 and imem_ready=0.
- Response:
  - On imem_rvalid: outstanding--.
  - If discard>0: discard--, word dropped.
  - Otherwise push {imem_rdata, pc of that request} into the FIFO. The PC comes from a per-request PC queue of MAX_OUTSTANDING entries.
  - The credit rule above guarantees the FIFO never overflows.
- Output: the FIFO head is registered; earliest instr_valid is the cycle after imem_rvalid. Pop on instr_valid & instr_ready. Push and pop in the same cycle keep fifo_count unchanged.
- Redirect (redirect_valid=1 on an edge, RUN):
  - Flush the FIFO; the same-cycle pop is ignored.
  - discard = outstanding − (1 if a response arrives that cycle).
  - Any non-discarded response arriving that cycle is also dropped.
  - fetch_pc = {redirect_pc[31:2], 2'b00}. imem_req=0 during the redirect cycle.
  - instr_valid=0 the next cycle. The first request to the target issues the next cycle.
  - A redirect during BOOT overrides RESET_PC.
- Back-to-back redirects: the latest wins; discard accumulates correctly.
- Reset mid-operation: immediate return to reset state. In-flight responses after reset release are ignored; the memory side is also reset.
- Counters: outstanding and discard are $clog2(MAX_OUTSTANDING+1) bits; fifo_count is $clog2(DEPTH+1) bits. Pointers wrap modulo DEPTH.
- Assertions: no imem_rvalid with outstanding=0; no push when full.

Decomposition:
- Shared package rv_fetch_pkg: XLEN=32, RESET_PC default, fetch FSM state typedef {BOOT, RUN}, fifo entry typedef {pc[31:0], instr[31:0]}.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count, flush input), instantiated for the prefetch buffer and the in-flight PC queue.

Test Plan:
- Reset, imem_ready=1, 1-cycle memory latency, instr_ready=1 → addresses 0,4,8,… issued from the second post-reset cycle; instr_pc/instr sequence matches memory; instr_pc_plus4 = instr_pc+4.
- instr_ready=0 for 20 cycles → exactly DEPTH=4 words buffered, imem_req drops to 0; instr_ready=1 then drains PCs 0,4,8,12 in order with no loss.
- imem_ready=0 for 3 cycles with imem_req=1 → imem_addr held constant; no duplicate or skipped PC.
- 2 requests in flight (PC 8, 12) plus redirect_pc=32'h0000_0103 → both responses dropped; next instr_pc=0x100; FIFO flushed the cycle after the redirect.
- Redirect in the same cycle as a response and a pop → response dropped, no FIFO underflow; next valid instr_pc = target.
- fetch_pc=0xFFFF_FFFC → next request address 0x0000_0000; instr_pc_plus4 for head 0xFFFF_FFFC = 0. Asserting rst mid-stream clears instr_valid asynchronously and fetch restarts at RESET_PC.
